// File: rtl/axil_mux_wr.sv
// AXI-Lite write-channel mux: latches the arbiter's one-hot grant and steers the granted master's
// AW/W to the slave port, then returns B, holding the selection until the B handshake completes.
module axil_mux_wr #(
    parameter int NUMBER_MASTER = 2,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    output logic [NUMBER_MASTER-1:0]            request_wr,
    input  logic [NUMBER_MASTER-1:0]            grant_wr,
    input  logic [NUMBER_MASTER*ADDR_WIDTH-1:0] m_axil_awaddr,
    input  logic [NUMBER_MASTER-1:0]            m_axil_awvalid,
    output logic [NUMBER_MASTER-1:0]            m_axil_awready,
    input  logic [NUMBER_MASTER*DATA_WIDTH-1:0] m_axil_wdata,
    input  logic [NUMBER_MASTER*STRB_WIDTH-1:0] m_axil_wstrb,
    input  logic [NUMBER_MASTER-1:0]            m_axil_wvalid,
    output logic [NUMBER_MASTER-1:0]            m_axil_wready,
    output logic [NUMBER_MASTER*2-1:0]          m_axil_bresp,
    output logic [NUMBER_MASTER-1:0]            m_axil_bvalid,
    input  logic [NUMBER_MASTER-1:0]            m_axil_bready,
    output logic [ADDR_WIDTH-1:0]               s_axil_awaddr,
    output logic                                s_axil_awvalid,
    input  logic                                s_axil_awready,
    output logic [DATA_WIDTH-1:0]               s_axil_wdata,
    output logic [STRB_WIDTH-1:0]               s_axil_wstrb,
    output logic                                s_axil_wvalid,
    input  logic                                s_axil_wready,
    input  logic [1:0]                          s_axil_bresp,
    input  logic                                s_axil_bvalid,
    output logic                                s_axil_bready,
    output logic                                err_multi_grant
);

    localparam int SEL_W = $clog2(NUMBER_MASTER);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [SEL_W-1:0]         r_sel, w_sel_nxt;
    logic                     r_aw_done, w_aw_done_nxt;
    logic                     r_w_done, w_w_done_nxt;
    logic                     r_err, w_err_nxt;
    logic                     w_s_awvalid, w_s_wvalid, w_s_bready;
    logic [NUMBER_MASTER-1:0] w_m_awready, w_m_wready, w_m_bvalid;
    logic [NUMBER_MASTER*2-1:0] w_bresp;
    logic                     w_aw_hs, w_w_hs, w_b_hs;

    function automatic logic [SEL_W-1:0] lowest_idx(input logic [NUMBER_MASTER-1:0] vec);
        logic [SEL_W-1:0] idx;
        idx = {SEL_W{1'b0}};
        for (int i = NUMBER_MASTER - 1; i >= 0; i--) begin
            if (vec[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

    function automatic logic multi_hot(input logic [NUMBER_MASTER-1:0] vec);
        return (vec & (vec - {{(NUMBER_MASTER-1){1'b0}}, 1'b1})) != {NUMBER_MASTER{1'b0}};
    endfunction

    assign request_wr = m_axil_awvalid | m_axil_wvalid;

    // Handshake strobes decoded from state; done flags suppress repeat transfers within a transaction.
    always_comb begin
        w_s_awvalid = 1'b0;
        w_s_wvalid  = 1'b0;
        w_s_bready  = 1'b0;
        w_m_awready = {NUMBER_MASTER{1'b0}};
        w_m_wready  = {NUMBER_MASTER{1'b0}};
        w_m_bvalid  = {NUMBER_MASTER{1'b0}};
        case (r_state)
            ST_ADDR: begin
                w_s_awvalid        = m_axil_awvalid[r_sel] & ~r_aw_done;
                w_m_awready[r_sel] = s_axil_awready & ~r_aw_done;
                w_s_wvalid         = m_axil_wvalid[r_sel] & ~r_w_done;
                w_m_wready[r_sel]  = s_axil_wready & ~r_w_done;
            end
            ST_RESP: begin
                w_m_bvalid[r_sel] = s_axil_bvalid;
                w_s_bready        = m_axil_bready[r_sel];
            end
            default: begin
                w_s_awvalid = 1'b0;
            end
        endcase
    end

    assign w_aw_hs = w_s_awvalid & s_axil_awready;
    assign w_w_hs  = w_s_wvalid & s_axil_wready;
    assign w_b_hs  = (r_state == ST_RESP) & s_axil_bvalid & m_axil_bready[r_sel];

    // Next-state, selection and sticky multi-grant detection.
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        w_err_nxt     = r_err;
        case (r_state)
            ST_IDLE: begin
                if (grant_wr != {NUMBER_MASTER{1'b0}}) begin
                    w_state_nxt   = ST_ADDR;
                    w_sel_nxt     = lowest_idx(grant_wr);
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    w_err_nxt     = r_err | multi_hot(grant_wr);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ADDR: begin
                w_aw_done_nxt = r_aw_done | w_aw_hs;
                w_w_done_nxt  = r_w_done | w_w_hs;
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_RESP: begin
                if (w_b_hs) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state   <= ST_IDLE;
            r_sel     <= {SEL_W{1'b0}};
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Response routing: only the selected master's slice carries the slave response.
    always_comb begin
        w_bresp                = {(NUMBER_MASTER*2){1'b0}};
        w_bresp[r_sel*2 +: 2]  = s_axil_bresp;
    end

    // Everything toward either side is forced quiet while reset is held.
    assign s_axil_awvalid  = w_s_awvalid & aresetn;
    assign s_axil_wvalid   = w_s_wvalid & aresetn;
    assign s_axil_bready   = w_s_bready & aresetn;
    assign m_axil_awready  = w_m_awready & {NUMBER_MASTER{aresetn}};
    assign m_axil_wready   = w_m_wready & {NUMBER_MASTER{aresetn}};
    assign m_axil_bvalid   = w_m_bvalid & {NUMBER_MASTER{aresetn}};
    assign s_axil_awaddr   = aresetn ? m_axil_awaddr[r_sel*ADDR_WIDTH +: ADDR_WIDTH] : {ADDR_WIDTH{1'b0}};
    assign s_axil_wdata    = aresetn ? m_axil_wdata[r_sel*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'b0}};
    assign s_axil_wstrb    = aresetn ? m_axil_wstrb[r_sel*STRB_WIDTH +: STRB_WIDTH] : {STRB_WIDTH{1'b0}};
    assign m_axil_bresp    = aresetn ? w_bresp : {(NUMBER_MASTER*2){1'b0}};
    assign err_multi_grant = r_err;

endmodule

// File: tb/tb_axil_mux_wr.sv
// Self-checking bench for axil_mux_wr: directed scenarios plus randomized transactions,
// each cycle compared against a transaction-level model of the write channel.
module tb_axil_mux_wr;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int HW = 3 + 3 * NM;

    logic              clk = 1'b0;
    logic              aresetn;
    logic [NM-1:0]     request_wr, grant_wr;
    logic [NM*AW-1:0]  m_axil_awaddr;
    logic [NM-1:0]     m_axil_awvalid, m_axil_awready;
    logic [NM*DW-1:0]  m_axil_wdata;
    logic [NM*SW-1:0]  m_axil_wstrb;
    logic [NM-1:0]     m_axil_wvalid, m_axil_wready;
    logic [NM*2-1:0]   m_axil_bresp;
    logic [NM-1:0]     m_axil_bvalid, m_axil_bready;
    logic [AW-1:0]     s_axil_awaddr;
    logic              s_axil_awvalid, s_axil_awready;
    logic [DW-1:0]     s_axil_wdata;
    logic [SW-1:0]     s_axil_wstrb;
    logic              s_axil_wvalid, s_axil_wready;
    logic [1:0]        s_axil_bresp;
    logic              s_axil_bvalid, s_axil_bready;
    logic              err_multi_grant;

    int   n_vec = 0;
    int   n_err = 0;
    logic exp_err;
    int   last_sel;

    always #5 clk = ~clk;

    axil_mux_wr #(.NUMBER_MASTER(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk(clk), .aresetn(aresetn), .request_wr(request_wr), .grant_wr(grant_wr),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid),
        .m_axil_wready(m_axil_wready), .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
        .m_axil_bready(m_axil_bready), .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid),
        .s_axil_awready(s_axil_awready), .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp),
        .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready), .err_multi_grant(err_multi_grant)
    );

    task automatic randomize_master(input int i);
        m_axil_awvalid[i]            = 1'($urandom);
        m_axil_wvalid[i]             = 1'($urandom);
        m_axil_bready[i]             = 1'($urandom);
        m_axil_awaddr[i*AW +: AW]    = $urandom;
        m_axil_wdata[i*DW +: DW]     = $urandom;
        m_axil_wstrb[i*SW +: SW]     = 4'($urandom);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        for (int i = 0; i < NM; i++) randomize_master(i);
        grant_wr = 2'($urandom);
        s_axil_awready = 1'b1; s_axil_wready = 1'b1; s_axil_bvalid = 1'b1;
        s_axil_bresp = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NM; i++) randomize_master(i);
        m_axil_awvalid = 2'b01; m_axil_wvalid = 2'b10;
        #1;
        n_vec++;
        if ({s_axil_awvalid, s_axil_wvalid, s_axil_bready, m_axil_awready, m_axil_wready, m_axil_bvalid} !== {HW{1'b0}}) begin
            n_err++;
            $display("FAIL reset_handshake got %b exp 0", {s_axil_awvalid, s_axil_wvalid, s_axil_bready, m_axil_awready, m_axil_wready, m_axil_bvalid});
        end
        n_vec++;
        if ({s_axil_awaddr, s_axil_wdata, s_axil_wstrb, m_axil_bresp} !== {(AW+DW+SW+2*NM){1'b0}}) begin
            n_err++;
            $display("FAIL reset_payload got %h exp 0", {s_axil_awaddr, s_axil_wdata, s_axil_wstrb, m_axil_bresp});
        end
        n_vec++;
        if (err_multi_grant !== 1'b0) begin
            n_err++;
            $display("FAIL reset_err got %b exp 0", err_multi_grant);
        end
        n_vec++;
        if (request_wr !== 2'b11) begin
            n_err++;
            $display("FAIL reset_request got %b exp 11", request_wr);
        end
        exp_err  = 1'b0;
        last_sel = 0;
    endtask

    // One idle cycle with busy-looking inputs: nothing may be forwarded, payload follows the held selection.
    task automatic idle_check();
        logic [AW+DW+SW-1:0] e_pay;
        logic [2*NM-1:0]     e_br;
        @(posedge clk); #1;
        aresetn  = 1'b1;
        grant_wr = '0;
        for (int i = 0; i < NM; i++) randomize_master(i);
        s_axil_awready = 1'b1; s_axil_wready = 1'b1; s_axil_bvalid = 1'b1;
        s_axil_bresp = 2'($urandom);
        #1;
        e_pay = {m_axil_awaddr[last_sel*AW +: AW], m_axil_wdata[last_sel*DW +: DW], m_axil_wstrb[last_sel*SW +: SW]};
        e_br  = '0;
        e_br[last_sel*2 +: 2] = s_axil_bresp;
        n_vec++;
        if ({s_axil_awvalid, s_axil_wvalid, s_axil_bready, m_axil_awready, m_axil_wready, m_axil_bvalid} !== {HW{1'b0}}) begin
            n_err++;
            $display("FAIL idle_handshake got %b exp 0", {s_axil_awvalid, s_axil_wvalid, s_axil_bready, m_axil_awready, m_axil_wready, m_axil_bvalid});
        end
        n_vec++;
        if ({s_axil_awaddr, s_axil_wdata, s_axil_wstrb} !== e_pay) begin
            n_err++;
            $display("FAIL idle_payload got %h exp %h", {s_axil_awaddr, s_axil_wdata, s_axil_wstrb}, e_pay);
        end
        n_vec++;
        if (m_axil_bresp !== e_br) begin
            n_err++;
            $display("FAIL idle_bresp got %b exp %b", m_axil_bresp, e_br);
        end
        n_vec++;
        if (request_wr !== (m_axil_awvalid | m_axil_wvalid)) begin
            n_err++;
            $display("FAIL idle_request got %b exp %b", request_wr, m_axil_awvalid | m_axil_wvalid);
        end
        n_vec++;
        if (err_multi_grant !== exp_err) begin
            n_err++;
            $display("FAIL idle_err got %b exp %b", err_multi_grant, exp_err);
        end
    endtask

    // Runs one write for master m; cycle 0 is the IDLE cycle that sees grant g0, later cycles see g1.
    // sticky keeps the master's valids raised after their handshake; rst_at pulses reset on that cycle.
    task automatic run_txn(input int m, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [SW-1:0] strb, input logic [1:0] resp,
                           input int aw_dly, input int w_dly, input int awr_dly, input int wr_dly,
                           input int bv_dly, input int br_dly,
                           input logic [NM-1:0] g0, input logic [NM-1:0] g1,
                           input bit sticky, input int rst_at);
        int phase, r;
        bit aw_done, w_done, fin;
        logic e_awv, e_wv, e_bready;
        logic [NM-1:0] e_mawr, e_mwr, e_mbv;
        logic [HW-1:0] e_hs, a_hs;
        logic [2*NM-1:0] e_br;
        phase = 0; r = 0; aw_done = 0; w_done = 0; fin = 0;
        for (int t = 0; t < 200 && !fin; t++) begin
            @(posedge clk); #1;
            aresetn  = (t == rst_at) ? 1'b0 : 1'b1;
            grant_wr = (t == 0) ? g0 : g1;
            for (int i = 0; i < NM; i++) if (i != m) randomize_master(i);
            m_axil_awaddr[m*AW +: AW] = addr;
            m_axil_wdata[m*DW +: DW]  = data;
            m_axil_wstrb[m*SW +: SW]  = strb;
            m_axil_awvalid[m] = (t >= aw_dly) && (sticky || !aw_done);
            m_axil_wvalid[m]  = (t >= w_dly) && (sticky || !w_done);
            s_axil_awready    = (t >= awr_dly);
            s_axil_wready     = (t >= wr_dly);
            s_axil_bresp      = resp;
            if (phase == 2) begin
                s_axil_bvalid    = (r >= bv_dly);
                m_axil_bready[m] = (r >= br_dly);
            end else begin
                s_axil_bvalid    = 1'($urandom);
                m_axil_bready[m] = 1'($urandom);
            end
            #1;
            e_awv = 1'b0; e_wv = 1'b0; e_bready = 1'b0;
            e_mawr = '0; e_mwr = '0; e_mbv = '0;
            if (aresetn && phase == 1) begin
                e_awv     = m_axil_awvalid[m] && !aw_done;
                e_mawr[m] = s_axil_awready && !aw_done;
                e_wv      = m_axil_wvalid[m] && !w_done;
                e_mwr[m]  = s_axil_wready && !w_done;
            end
            if (aresetn && phase == 2) begin
                e_mbv[m] = s_axil_bvalid;
                e_bready = m_axil_bready[m];
            end
            e_hs = {e_awv, e_wv, e_bready, e_mawr, e_mwr, e_mbv};
            a_hs = {s_axil_awvalid, s_axil_wvalid, s_axil_bready, m_axil_awready, m_axil_wready, m_axil_bvalid};
            n_vec++;
            if (a_hs !== e_hs) begin
                n_err++;
                $display("FAIL txn_handshake m=%0d t=%0d got %b exp %b", m, t, a_hs, e_hs);
            end
            if (!aresetn || phase > 0) begin
                e_br = '0;
                if (aresetn) e_br[m*2 +: 2] = resp;
                n_vec++;
                if ({s_axil_awaddr, s_axil_wdata, s_axil_wstrb} !== (aresetn ? {addr, data, strb} : {(AW+DW+SW){1'b0}})) begin
                    n_err++;
                    $display("FAIL txn_payload m=%0d t=%0d got %h exp %h", m, t, {s_axil_awaddr, s_axil_wdata, s_axil_wstrb}, {addr, data, strb});
                end
                n_vec++;
                if (m_axil_bresp !== e_br) begin
                    n_err++;
                    $display("FAIL txn_bresp m=%0d t=%0d got %b exp %b", m, t, m_axil_bresp, e_br);
                end
            end
            n_vec++;
            if (request_wr !== (m_axil_awvalid | m_axil_wvalid)) begin
                n_err++;
                $display("FAIL txn_request t=%0d got %b exp %b", t, request_wr, m_axil_awvalid | m_axil_wvalid);
            end
            n_vec++;
            if (err_multi_grant !== exp_err) begin
                n_err++;
                $display("FAIL txn_err t=%0d got %b exp %b", t, err_multi_grant, exp_err);
            end
            if (!aresetn) begin
                fin = 1; exp_err = 1'b0; last_sel = 0;
            end else if (phase == 0) begin
                phase = 1; last_sel = m;
                if ($countones(g0) > 1) exp_err = 1'b1;
            end else if (phase == 1) begin
                aw_done = aw_done || (e_awv && s_axil_awready);
                w_done  = w_done || (e_wv && s_axil_wready);
                if (aw_done && w_done) phase = 2;
            end else begin
                if (s_axil_bvalid && m_axil_bready[m]) fin = 1;
                else r++;
            end
        end
        if (!fin) begin
            n_vec++; n_err++;
            $display("FAIL txn_timeout m=%0d phase=%0d", m, phase);
        end
        idle_check();
    endtask

    task automatic test_single_write();
        run_txn(0, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 1'b0, -1);
    endtask

    task automatic test_w_before_aw();
        run_txn(1, $urandom, $urandom, 4'($urandom), 2'b01, 2, 0, 5, 0, 1, 0, 2'b10, 2'b10, 1'b1, -1);
    endtask

    task automatic test_bready_stall();
        run_txn(0, $urandom, $urandom, 4'($urandom), 2'b00, 0, 0, 0, 0, 0, 4, 2'b01, 2'b01, 1'b0, -1);
    endtask

    task automatic test_grant_switch();
        run_txn(0, $urandom, $urandom, 4'($urandom), 2'b11, 1, 2, 0, 3, 0, 1, 2'b01, 2'b10, 1'b0, -1);
    endtask

    task automatic test_multi_grant();
        run_txn(0, $urandom, $urandom, 4'($urandom), 2'b00, 0, 0, 1, 0, 0, 0, 2'b11, 2'b00, 1'b0, -1);
        run_txn(1, $urandom, $urandom, 4'($urandom), 2'b01, 0, 1, 0, 0, 1, 1, 2'b10, 2'b00, 1'b0, -1);
        n_vec++;
        if (err_multi_grant !== 1'b1) begin
            n_err++;
            $display("FAIL multi_grant_sticky got %b exp 1", err_multi_grant);
        end
    endtask

    task automatic test_reset_mid();
        run_txn(0, $urandom, $urandom, 4'($urandom), 2'b00, 0, 5, 0, 0, 0, 0, 2'b01, 2'b01, 1'b0, 3);
        run_txn(1, $urandom, $urandom, 4'($urandom), 2'b10, 0, 0, 1, 2, 0, 0, 2'b10, 2'b10, 1'b0, -1);
    endtask

    task automatic test_random();
        int m;
        logic [NM-1:0] g0;
        for (int k = 0; k < 24; k++) begin
            m  = $urandom_range(0, NM - 1);
            g0 = '0;
            g0[m] = 1'b1;
            if (m == 0 && $urandom_range(0, 5) == 0) g0 = 2'b11;
            run_txn(m, $urandom, $urandom, 4'($urandom), 2'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 3), $urandom_range(0, 3), g0, 2'($urandom), 1'($urandom), -1);
        end
    endtask

    initial begin
        aresetn = 1'b0; grant_wr = '0;
        m_axil_awaddr = '0; m_axil_awvalid = '0; m_axil_wdata = '0; m_axil_wstrb = '0;
        m_axil_wvalid = '0; m_axil_bready = '0;
        s_axil_awready = 1'b0; s_axil_wready = 1'b0; s_axil_bresp = 2'b00; s_axil_bvalid = 1'b0;
        exp_err = 1'b0; last_sel = 0;
        test_reset();
        test_single_write();
        test_w_before_aw();
        test_bready_stall();
        test_grant_switch();
        test_multi_grant();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
